mcb_write_gen: RTL and testbench
================================

MCB_WRITE_GEN -- requirements
Module: mcb_write_gen

Interface
REQ-001 Parameter BURST_LEN, default 7'd64, beats per write pass (1..64).
REQ-002 Parameter ADDR_INC, default 12'h400, address step between passes.
REQ-003 Parameter END_ADDR, default 29'h10000000 - ADDR_INC, last pass address before wrap.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 run  input  1  pass enable; low lets the current pass finish, then the block holds in IDLE.
REQ-007 u_wr_rdy  input  1  MCB write FIFO can accept a beat this cycle.
REQ-008 u_wr_cmd_done  input  1  MCB accepted the write command (single-cycle pulse).
REQ-009 u_wr_en  output  1  write-data strobe; a beat transfers when u_wr_en && u_wr_rdy.
REQ-010 u_wr_data  output  128  write data beat.
REQ-011 u_wr_cmd_en  output  1  write command request.
REQ-012 u_wr_addr  output  30  write command byte address.
REQ-013 u_wr_len  output  7  write command length in beats.
REQ-014 pass_done  output  1  single-cycle pulse at the end of each completed pass.

Function
REQ-015 State machine: IDLE -> FILL -> CMD -> DONE -> IDLE.
REQ-016 IDLE: outputs deasserted; beat counter cleared; go to FILL when run=1.
REQ-017 FILL: u_wr_en=1; each transferred beat increments a 7-bit beat counter; no increment when u_wr_rdy=0.
REQ-018 Data: beat index even -> 128'hAA..AA, odd -> 128'h55..55; beat 0 always AA; data updates only after a transfer.
REQ-019 FILL -> CMD in the cycle after the BURST_LEN-th beat transfers; u_wr_en is low in that cycle (no extra beat).
REQ-020 CMD: u_wr_cmd_en=1, u_wr_addr={1'b0, addr_set}, u_wr_len=BURST_LEN; all three held stable until u_wr_cmd_done.
REQ-021 u_wr_cmd_done seen in CMD: u_wr_cmd_en clears next cycle; state -> DONE.
REQ-022 DONE: pass_done=1 for exactly one cycle; addr_set advances; state -> IDLE.
REQ-023 Address: addr_set += ADDR_INC when addr_set < END_ADDR, else wraps to 0; 29-bit arithmetic, no carry-out.
REQ-024 u_wr_cmd_done outside CMD is ignored; no state or address change.
REQ-025 run deasserted during FILL or CMD does not abort; the pass completes and the block stays in IDLE.
REQ-026 Data is always written before its command (MCB rule); u_wr_cmd_en and u_wr_en are never high together.

Reset
REQ-027 Under rst_n=0: state IDLE, u_wr_en=0, u_wr_cmd_en=0, u_wr_data=AA..AA, u_wr_addr=0, u_wr_len=BURST_LEN, pass_done=0, addr_set=0, beat counter=0.
REQ-028 Reset asserted mid-pass abandons the pass; no pass_done is produced, and the next pass restarts at address 0.

Configuration
REQ-029 Macro MCB_WR_ERR_INJECT_EN defined: input err_inject (1 bit) is added; if err_inject=1 in the IDLE->FILL cycle, beat 0 of that pass is 128'hAA..AB (bit 0 flipped); all other beats and passes are unchanged.
REQ-030 Macro undefined: no err_inject port; the pattern is always clean.

Structure
REQ-031 Shared package mcb_test_pkg holds PAT_EVEN (AA..AA), PAT_ODD (55..55), the default ADDR_INC and END_ADDR, and the state-encoding typedef; the read tester uses the same package.
REQ-032 Sub-module mcb_test_addr_gen (addr_set register, advance/wrap logic) is shared with the read tester.

Verification
REQ-033 run=1, u_wr_rdy=1, done 3 cycles after cmd_en -> 64 beats alternating AA/55, then cmd_en with addr=0, len=64, then pass_done; the second pass uses addr=0x400.
REQ-034 u_wr_rdy toggling 1/0 every cycle -> still exactly 64 beats, ordering intact, no beat duplicated or skipped.
REQ-035 addr_set preloaded to END_ADDR, pass completes -> next pass addr=0.
REQ-036 rst_n low at beat 30 -> all outputs reach reset values next edge; the following pass has addr=0 and beat 0=AA.
REQ-037 Spurious u_wr_cmd_done during FILL -> ignored; addr unchanged; pass completes normally.
REQ-038 With MCB_WR_ERR_INJECT_EN and err_inject=1 at pass start -> beat 0=AA..AB; the next pass without inject is clean.

Source files
------------

// File: rtl/mcb_test_pkg.sv
// Shared constants, state encoding and pattern helper for the MCB write/read testers.
package mcb_test_pkg;

  localparam logic [127:0] PAT_EVEN     = {16{8'hAA}};
  localparam logic [127:0] PAT_ODD      = {16{8'h55}};
  localparam logic [11:0]  DEF_ADDR_INC = 12'h400;
  localparam logic [28:0]  DEF_END_ADDR = 29'h1000_0000 - {17'd0, DEF_ADDR_INC};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_CMD  = 2'd2,
    ST_DONE = 2'd3
  } mcb_state_e;

  function automatic logic [127:0] beat_pattern(input logic [6:0] idx);
    return idx[0] ? PAT_ODD : PAT_EVEN;
  endfunction

endpackage

// File: rtl/mcb_test_addr_gen.sv
// Pass base address register: steps by ADDR_INC on advance, wraps to 0 after END_ADDR.
module mcb_test_addr_gen
  import mcb_test_pkg::*;
#(
  parameter logic [11:0] ADDR_INC = DEF_ADDR_INC,
  parameter logic [28:0] END_ADDR = DEF_END_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [28:0] addr_set
);

  logic [28:0] addr_set_q;
  logic [28:0] addr_set_d;

  always_comb begin
    addr_set_d = addr_set_q;
    if (advance) begin
      addr_set_d = (addr_set_q < END_ADDR) ? addr_set_q + {17'd0, ADDR_INC} : 29'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) addr_set_q <= 29'd0;
    else        addr_set_q <= addr_set_d;
  end

  assign addr_set = addr_set_q;

endmodule

// File: rtl/mcb_write_gen.sv
// MCB write pattern generator: fills BURST_LEN beats of AA/55 data, then issues the write command.
// Optional MCB_WR_ERR_INJECT_EN adds err_inject, flipping bit 0 of beat 0 for one pass.
//
// state   | meaning
// IDLE    | outputs quiet, waiting for run
// FILL    | streaming data beats into the write FIFO
// CMD     | write command held until u_wr_cmd_done
// DONE    | one-cycle pass_done, base address advances
module mcb_write_gen
  import mcb_test_pkg::*;
#(
  parameter logic [6:0]  BURST_LEN = 7'd64,
  parameter logic [11:0] ADDR_INC  = DEF_ADDR_INC,
  parameter logic [28:0] END_ADDR  = 29'h1000_0000 - {17'd0, ADDR_INC}
) (
`ifdef MCB_WR_ERR_INJECT_EN
  input  logic         err_inject,
`endif
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         u_wr_rdy,
  input  logic         u_wr_cmd_done,
  output logic         u_wr_en,
  output logic [127:0] u_wr_data,
  output logic         u_wr_cmd_en,
  output logic [29:0]  u_wr_addr,
  output logic [6:0]   u_wr_len,
  output logic         pass_done
);

  mcb_state_e   state_q, state_d;
  logic         wr_en_q, wr_en_d;
  logic [127:0] data_q, data_d;
  logic         cmd_en_q, cmd_en_d;
  logic [29:0]  addr_q, addr_d;
  logic [6:0]   len_q, len_d;
  logic [6:0]   beat_cnt_q, beat_cnt_d;
  logic         pass_done_q, pass_done_d;
  logic [6:0]   beat_nxt;
  logic [28:0]  addr_set;
  logic         inject;

`ifdef MCB_WR_ERR_INJECT_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  mcb_test_addr_gen #(
    .ADDR_INC (ADDR_INC),
    .END_ADDR (END_ADDR)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (state_q == ST_DONE),
    .addr_set (addr_set)
  );

  assign beat_nxt = beat_cnt_q + 7'd1;

  always_comb begin
    state_d     = state_q;
    wr_en_d     = wr_en_q;
    data_d      = data_q;
    cmd_en_d    = cmd_en_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    pass_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wr_en_d    = 1'b0;
        cmd_en_d   = 1'b0;
        beat_cnt_d = 7'd0;
        data_d     = PAT_EVEN;
        if (run) begin
          state_d = ST_FILL;
          wr_en_d = 1'b1;
          if (inject) data_d = PAT_EVEN ^ 128'd1;
        end
      end
      ST_FILL: begin
        if (wr_en_q && u_wr_rdy) begin
          beat_cnt_d = beat_nxt;
          data_d     = beat_pattern(beat_nxt);
          // Last beat: drop the strobe in the same edge so no extra beat leaks out.
          if (beat_nxt == BURST_LEN) begin
            state_d  = ST_CMD;
            wr_en_d  = 1'b0;
            cmd_en_d = 1'b1;
            addr_d   = {1'b0, addr_set};
            len_d    = BURST_LEN;
          end
        end
      end
      ST_CMD: begin
        if (u_wr_cmd_done) begin
          cmd_en_d    = 1'b0;
          state_d     = ST_DONE;
          pass_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      data_q      <= PAT_EVEN;
      cmd_en_q    <= 1'b0;
      addr_q      <= 30'd0;
      len_q       <= BURST_LEN;
      beat_cnt_q  <= 7'd0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      cmd_en_q    <= cmd_en_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign u_wr_en     = wr_en_q;
  assign u_wr_data   = data_q;
  assign u_wr_cmd_en = cmd_en_q;
  assign u_wr_addr   = addr_q;
  assign u_wr_len    = len_q;
  assign pass_done   = pass_done_q;

endmodule

// File: tb/tb_mcb_write_gen.sv
// Scoreboard bench for mcb_write_gen: expected beats/commands queued by stimulus, checked by a monitor.
module tb_mcb_write_gen;
  import mcb_test_pkg::*;

  localparam logic [6:0]  BL   = 7'd64;
  localparam logic [11:0] INC  = 12'h400;
  localparam logic [28:0] ENDA = 29'h800;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run = 1'b0;
  logic         u_wr_rdy = 1'b0;
  logic         u_wr_cmd_done = 1'b0;
`ifdef MCB_WR_ERR_INJECT_EN
  logic         err_inject = 1'b0;
`endif
  logic         u_wr_en;
  logic [127:0] u_wr_data;
  logic         u_wr_cmd_en;
  logic [29:0]  u_wr_addr;
  logic [6:0]   u_wr_len;
  logic         pass_done;

  int tests = 0;
  int fails = 0;
  logic [127:0] beat_q[$];
  logic [29:0]  cmd_q[$];
  int exp_done = 0;
  int done_seen = 0;
  int beats_seen = 0;
  int rdy_mode = 0;
  int cmd_cnt = 0;
  bit rst_at_30 = 1'b0;
  bit spurious = 1'b0;

  mcb_write_gen #(
    .BURST_LEN (BL),
    .ADDR_INC  (INC),
    .END_ADDR  (ENDA)
  ) dut (
`ifdef MCB_WR_ERR_INJECT_EN
    .err_inject    (err_inject),
`endif
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .u_wr_rdy      (u_wr_rdy),
    .u_wr_cmd_done (u_wr_cmd_done),
    .u_wr_en       (u_wr_en),
    .u_wr_data     (u_wr_data),
    .u_wr_cmd_en   (u_wr_cmd_en),
    .u_wr_addr     (u_wr_addr),
    .u_wr_len      (u_wr_len),
    .pass_done     (pass_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: runs on the falling edge, sees what will transfer at the next rising edge.
  logic        cmd_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic [29:0] cmd_addr_l = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_en_cmd_en_exclusive", u_wr_en & u_wr_cmd_en, 0);
      if (u_wr_en && u_wr_rdy) begin
        beats_seen++;
        if (beat_q.size() == 0) check("beat_unexpected", 1, 0);
        else check($sformatf("beat%0d", beats_seen - 1), u_wr_data, beat_q.pop_front());
      end
      if (u_wr_cmd_en && !cmd_prev) begin
        if (cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
        else check("cmd_addr", u_wr_addr, cmd_q.pop_front());
        check("cmd_len", u_wr_len, BL);
        cmd_addr_l = u_wr_addr;
      end else if (u_wr_cmd_en) begin
        check("cmd_addr_stable", u_wr_addr, cmd_addr_l);
        check("cmd_len_stable", u_wr_len, BL);
      end
      if (pass_done) begin
        done_seen++;
        check("pass_done_single", done_prev, 0);
      end
      cmd_prev  = u_wr_cmd_en;
      done_prev = pass_done;
    end else begin
      cmd_prev  = 1'b0;
      done_prev = 1'b0;
    end
  end

  // MCB side: ready pattern, command acknowledge 3 cycles after cmd_en, mid-pass reset.
  initial forever begin
    @(posedge clk); #1;
    if (rst_at_30 && beats_seen == 30) begin
      rst_n     = 1'b0;
      u_wr_rdy  = 1'b0;
      rst_at_30 = 1'b0;
      rdy_mode  = 2;
    end else begin
      case (rdy_mode)
        0:       u_wr_rdy = 1'b1;
        1:       u_wr_rdy = ~u_wr_rdy;
        default: u_wr_rdy = 1'b0;
      endcase
    end
    if (u_wr_cmd_en) cmd_cnt++;
    else cmd_cnt = 0;
    u_wr_cmd_done = (cmd_cnt == 3) || spurious;
    spurious = 1'b0;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, u_wr_en, 0);
    check({tag, "_cmd_en"}, u_wr_cmd_en, 0);
    check({tag, "_data"}, u_wr_data, PAT_EVEN);
    check({tag, "_addr"}, u_wr_addr, 0);
    check({tag, "_len"}, u_wr_len, BL);
    check({tag, "_pass_done"}, pass_done, 0);
  endtask

  task automatic run_pass(input logic [29:0] addr, input bit inj, input int mode,
                          input bit spur, input bit rst30, input bit keep_run);
    bit got;
    bit spur_sent;
    beats_seen = 0;
    for (int i = 0; i < int'(BL); i++)
      beat_q.push_back((i == 0 && inj) ? (PAT_EVEN ^ 128'd1) : beat_pattern(7'(i)));
    if (!rst30) begin
      cmd_q.push_back(addr);
      exp_done++;
    end
    rdy_mode  = mode;
    rst_at_30 = rst30;
    run       = 1'b1;
`ifdef MCB_WR_ERR_INJECT_EN
    err_inject = inj;
`endif
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = u_wr_en;
    end
    check("fill_start", got, 1);
`ifdef MCB_WR_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    if (!keep_run) run = 1'b0;
    got = 1'b0;
    spur_sent = 1'b0;
    for (int t = 0; t < 2000 && !got; t++) begin
      @(negedge clk);
      if (spur && !spur_sent && beats_seen >= 10) begin
        spurious  = 1'b1;
        spur_sent = 1'b1;
      end
      got = rst30 ? !rst_n : pass_done;
    end
    check(rst30 ? "reset_hit_beat30" : "pass_done_seen", got, 1);
    if (rst30) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midpass_reset");
      beat_q.delete();
      rst_n    = 1'b1;
      rdy_mode = 0;
      repeat (3) @(negedge clk);
    end else if (!keep_run) begin
      repeat (6) @(negedge clk);
      check("idle_after_run_low", {u_wr_en, u_wr_cmd_en}, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_pass(30'h000, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    run_pass(30'h400, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_pass(30'h800, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    run_pass(30'h000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_pass(30'h400, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    run_pass(30'h800, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    run_pass(30'h000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
`ifdef MCB_WR_ERR_INJECT_EN
    run_pass(30'h400, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    run_pass(30'h800, 1'b0, 0, 1'b0, 1'b0, 1'b0);
`endif

    repeat (10) @(negedge clk);
    check("beats_left", beat_q.size(), 0);
    check("cmds_left", cmd_q.size(), 0);
    check("pass_done_count", done_seen, exp_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
